// File: rtl/glyph_pixel_fetch.sv
// Glyph bit fetch from font flash through a one-byte cache; emits fg/bg colour per pixel.
// Hit: 1 cycle accept-to-pixel; miss: flash request/grant/data round trip; px_ready stalls via in_ready.
module glyph_pixel_fetch #(
  parameter int OFFS_W     = 30,
  parameter int CHAR_SHIFT = 13,
  parameter int FLASH_AW   = 27,
  parameter int COLOR_W    = 16,
  parameter int TAG_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OFFS_W-1:0]   in_bit_offset,
  input  logic [7:0]          in_char_code,
  input  logic [COLOR_W-1:0]  in_fg,
  input  logic [COLOR_W-1:0]  in_bg,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                fl_req,
  output logic [FLASH_AW-1:0] fl_addr,
  input  logic                fl_gnt,
  input  logic                fl_rvalid,
  input  logic [7:0]          fl_rdata,
  input  logic                cache_inv,
  output logic                px_valid,
  input  logic                px_ready,
  output logic [COLOR_W-1:0]  px_color,
  output logic [TAG_W-1:0]    px_tag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]          state;
  logic                c_valid;
  logic [FLASH_AW-1:0] c_addr;
  logic [7:0]          c_data;
  logic [FLASH_AW-1:0] l_addr;
  logic [2:0]          l_bitsel;
  logic [COLOR_W-1:0]  l_fg;
  logic [COLOR_W-1:0]  l_bg;

  logic [OFFS_W-1:0]   char_term;
  logic [OFFS_W-1:0]   full_addr;
  logic [FLASH_AW-1:0] byte_addr;
  logic [2:0]          bitsel;
  logic                hit;
  logic                accept;

  // Sum is truncated to OFFS_W bits, dropping the carry out.
  assign char_term = OFFS_W'(in_char_code) << CHAR_SHIFT;
  assign full_addr = in_bit_offset + char_term;
  assign byte_addr = full_addr[OFFS_W-1:3];
  assign bitsel    = 3'd7 - full_addr[2:0];
  // A same-cycle invalidate forces the lookup to miss.
  assign hit       = c_valid && !cache_inv && (c_addr == byte_addr);

  assign in_ready = rst_n && ((state == IDLE) || ((state == OUT) && px_ready));
  assign accept   = in_valid && in_ready;
  assign fl_req   = (state == REQ);
  assign fl_addr  = (state == REQ) ? l_addr : '0;
  assign px_valid = (state == OUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      c_valid  <= 1'b0;
      c_addr   <= '0;
      c_data   <= '0;
      l_addr   <= '0;
      l_bitsel <= '0;
      l_fg     <= '0;
      l_bg     <= '0;
      px_color <= '0;
      px_tag   <= '0;
    end else begin
      if (cache_inv)
        c_valid <= 1'b0;
      case (state)
        IDLE, OUT: begin
          if (accept) begin
            l_addr   <= byte_addr;
            l_bitsel <= bitsel;
            l_fg     <= in_fg;
            l_bg     <= in_bg;
            px_tag   <= in_tag;
            if (hit) begin
              px_color <= c_data[bitsel] ? in_fg : in_bg;
              state    <= OUT;
            end else begin
              state    <= REQ;
            end
          end else if (state == OUT && px_ready) begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (fl_gnt)
            state <= WAIT;
        end
        WAIT: begin
          if (fl_rvalid) begin
            c_data   <= fl_rdata;
            c_addr   <= l_addr;
            c_valid  <= !cache_inv;
            px_color <= fl_rdata[l_bitsel] ? l_fg : l_bg;
            state    <= OUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_pixel_fetch.sv
// Directed bench for glyph_pixel_fetch: miss/fill, hits, wrap, backpressure, invalidate, reset abort.
module tb_glyph_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_bit_offset;
  logic [7:0]  in_char_code;
  logic [15:0] in_fg, in_bg, in_tag;
  logic        fl_req;
  logic [26:0] fl_addr;
  logic        fl_gnt, fl_rvalid;
  logic [7:0]  fl_rdata;
  logic        cache_inv;
  logic        px_valid, px_ready;
  logic [15:0] px_color, px_tag;

  int tests = 0;
  int fails = 0;

  localparam logic [15:0] FG = 16'hF00D;
  localparam logic [15:0] BG = 16'h0BAD;

  glyph_pixel_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bit_offset(in_bit_offset), .in_char_code(in_char_code),
    .in_fg(in_fg), .in_bg(in_bg), .in_tag(in_tag),
    .fl_req(fl_req), .fl_addr(fl_addr), .fl_gnt(fl_gnt),
    .fl_rvalid(fl_rvalid), .fl_rdata(fl_rdata),
    .cache_inv(cache_inv),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_color(px_color), .px_tag(px_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [29:0] offs, input logic [7:0] ch, input logic [15:0] tg);
    in_valid      = 1'b1;
    in_bit_offset = offs;
    in_char_code  = ch;
    in_fg         = FG;
    in_bg         = BG;
    in_tag        = tg;
  endtask

  // Full miss round trip: accept at N, grant at N+2, data at N+4, pixel at N+5.
  task automatic miss_txn(input string nm, input logic [29:0] offs, input logic [7:0] ch,
                          input logic [15:0] tg, input logic [26:0] exp_addr,
                          input logic [7:0] rdata, input logic inv, input logic [15:0] exp_col);
    drive(offs, ch, tg);
    chk({nm, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({nm, "_fl_req_n1"}, fl_req, 1);
    chk({nm, "_fl_addr"}, fl_addr, exp_addr);
    chk({nm, "_px_valid_n1"}, px_valid, 0);
    tick();
    fl_gnt = 1'b1;
    chk({nm, "_fl_req_held"}, fl_req, 1);
    tick();
    fl_gnt = 1'b0;
    chk({nm, "_fl_req_drop"}, fl_req, 0);
    chk({nm, "_in_ready_wait"}, in_ready, 0);
    tick();
    fl_rvalid = 1'b1;
    fl_rdata  = rdata;
    cache_inv = inv;
    tick();
    fl_rvalid = 1'b0;
    cache_inv = 1'b0;
    chk({nm, "_px_valid"}, px_valid, 1);
    chk({nm, "_px_color"}, px_color, exp_col);
    chk({nm, "_px_tag"}, px_tag, tg);
    tick();
    chk({nm, "_px_done"}, px_valid, 0);
  endtask

  task automatic hit_txn(input string nm, input logic [29:0] offs, input logic [7:0] ch,
                         input logic [15:0] tg, input logic [15:0] exp_col);
    drive(offs, ch, tg);
    tick();
    in_valid = 1'b0;
    chk({nm, "_fl_req"}, fl_req, 0);
    chk({nm, "_px_valid"}, px_valid, 1);
    chk({nm, "_px_color"}, px_color, exp_col);
    chk({nm, "_px_tag"}, px_tag, tg);
    tick();
    chk({nm, "_px_done"}, px_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit_offset = '0; in_char_code = '0;
    in_fg = '0; in_bg = '0; in_tag = '0; fl_gnt = 1'b0; fl_rvalid = 1'b0;
    fl_rdata = '0; cache_inv = 1'b0; px_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fl_req", fl_req, 0);
    chk("rst_fl_addr", fl_addr, 0);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_px_color", px_color, 0);
    chk("rst_px_tag", px_tag, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // A=0x82105: byte 0x10420, bit 2 of 0x04 -> fg
    miss_txn("miss", 30'h105, 8'h41, 16'h1111, 27'h10420, 8'h04, 1'b0, FG);
    hit_txn("hit", 30'h106, 8'h41, 16'h2222, BG);

    // Back-to-back hits: bit selects 2,1,0 of 0x04 -> fg,bg,bg
    drive(30'h105, 8'h41, 16'hA0);
    tick();
    chk("b2b0_px_valid", px_valid, 1);
    chk("b2b0_color", px_color, FG);
    chk("b2b0_in_ready", in_ready, 1);
    drive(30'h106, 8'h41, 16'hA1);
    tick();
    chk("b2b1_px_valid", px_valid, 1);
    chk("b2b1_color", px_color, BG);
    chk("b2b1_tag", px_tag, 16'hA1);
    drive(30'h107, 8'h41, 16'hA2);
    tick();
    in_valid = 1'b0;
    chk("b2b2_px_valid", px_valid, 1);
    chk("b2b2_color", px_color, BG);
    chk("b2b2_fl_req", fl_req, 0);
    tick();
    chk("b2b_done", px_valid, 0);

    // Backpressure on a hit pixel
    px_ready = 1'b0;
    drive(30'h105, 8'h41, 16'h3333);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_px_valid", px_valid, 1);
      chk("bp_color", px_color, FG);
      chk("bp_tag", px_tag, 16'h3333);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    px_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_px_valid", px_valid, 1);
    tick();
    chk("bp_one_transfer", px_valid, 0);

    // Wrap: A=0x001FDFFF, byte 0x3FBFF, bit 0; invalidate coincides with the fill
    miss_txn("wrap_inv", 30'h3FFFFFFF, 8'hFF, 16'h4444, 27'h3FBFF, 8'h01, 1'b1, FG);
    miss_txn("wrap_refetch", 30'h3FFFFFFF, 8'hFF, 16'h4545, 27'h3FBFF, 8'h00, 1'b0, BG);
    hit_txn("wrap_hit", 30'h3FFFFFFF, 8'hFF, 16'h4646, BG);

    // Idle-cycle invalidate forces a refetch
    cache_inv = 1'b1;
    tick();
    cache_inv = 1'b0;
    miss_txn("inv_idle", 30'h3FFFFFFF, 8'hFF, 16'h5555, 27'h3FBFF, 8'h01, 1'b0, FG);

    // Reset while waiting for flash data
    drive(30'h105, 8'h41, 16'h6666);
    tick();
    in_valid = 1'b0;
    chk("rstw_fl_req", fl_req, 1);
    fl_gnt = 1'b1;
    tick();
    fl_gnt = 1'b0;
    chk("rstw_in_wait", fl_req, 0);
    rst_n = 1'b0;
    tick();
    chk("rstw_in_ready_rst", in_ready, 0);
    rst_n = 1'b1;
    tick();
    fl_rvalid = 1'b1;
    fl_rdata  = 8'hFF;
    tick();
    fl_rvalid = 1'b0;
    chk("rstw_px_valid", px_valid, 0);
    chk("rstw_fl_req_after", fl_req, 0);
    chk("rstw_in_ready", in_ready, 1);
    miss_txn("rstw_miss", 30'h106, 8'h41, 16'h7777, 27'h10420, 8'h02, 1'b0, FG);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glyph_pixel_fetch.md
# glyph_pixel_fetch

Downstream of the font-bitmap address calculation in pipe stage 2. Takes the scaled per-pixel bit offset plus the character code read from text RAM, adds the character offset, and fetches the containing byte from font flash. A one-byte cache avoids refetching. It extracts the glyph bit and emits a foreground or background colour per pixel to the next pipe stage over a valid/ready handshake.

## Interface
- OFFS_W, 30: width of incoming bit offset (font + scaled x/y, no character term)
- CHAR_SHIFT, 13: log2 bits per character bitmap (7 height bits + 6 width bits)
- FLASH_AW, 27: flash byte-address width (OFFS_W-3)
- COLOR_W, 16: pixel colour width
- TAG_W, 16: opaque sideband carried with each pixel

- clk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_bit_offset  in  OFFS_W  bit offset, character term excluded
- in_char_code  in  8  character code from text RAM
- in_fg / in_bg  in  COLOR_W  colours for glyph bit 1 / 0
- in_tag  in  TAG_W  sideband, passed through unchanged
- fl_req  out  1  flash read request, held until fl_gnt
- fl_addr  out  FLASH_AW  byte address, stable while fl_req
- fl_gnt  in  1  request accepted
- fl_rvalid  in  1  read data valid (one read outstanding max)
- fl_rdata  in  8  read byte
- cache_inv  in  1  invalidate cached byte (font table rewritten)
- px_valid  out  1  pixel valid
- px_ready  in  1  downstream accepts pixel
- px_color  out  COLOR_W  resolved colour
- px_tag  out  TAG_W  sideband of this pixel

## Operation
- Full bit address A = (in_bit_offset + (in_char_code << CHAR_SHIFT)) mod 2^OFFS_W. This is an unsigned OFFS_W-bit sum; the carry out is dropped.
- Byte address = A[OFFS_W-1:3]. Bit select = 7 - A[2:0], so bits are MSB-first within the byte.
- Cache: c_valid, c_addr, c_data. A hit occurs when c_valid and c_addr == byte address.
- FSM states: IDLE, REQ, WAIT, OUT.
  - IDLE: in_ready=1. On accept, latch the byte address, bit select, fg, bg and tag. On a hit, resolve the colour and go to OUT. On a miss, go to REQ.
  - REQ: fl_req=1 with fl_addr=latched byte address. When fl_gnt, go to WAIT.
  - WAIT: when fl_rvalid, load the cache from fl_rdata, resolve the colour from fl_rdata, and go to OUT.
  - OUT: px_valid=1. When px_ready and no new accept, go to IDLE. in_ready = px_ready, so a same-cycle accept gives back-to-back operation: a hit stays in OUT, a miss goes to REQ.
- Colour: px_color = selected bit ? fg : bg.
- px_color and px_tag are registered and hold stable while px_valid & !px_ready.
- fl_rvalid outside WAIT is ignored. fl_gnt outside REQ is ignored.
- cache_inv clears c_valid in the same cycle.
  - If it coincides with an accept, the lookup sees the invalidated cache, so the result is a miss.
  - If it coincides with the WAIT fill, the fill data is still used for the current pixel but c_valid stays 0.
- Reset: state to IDLE and c_valid to 0. Any later fl_rvalid from an aborted read is dropped.

## Timing
- Reset values while rst_n low and after: in_ready=0 during reset, then 1 in IDLE. fl_req=0, fl_addr=0, px_valid=0, px_color=0, px_tag=0.
- Hit latency: accept at cycle N gives px_valid at N+1. Sustained throughput is one pixel per cycle on hits with px_ready high.
- Miss latency: accept at N gives fl_req from N+1. fl_gnt at G (G ≥ N+1) gives WAIT from G+1. fl_rvalid at R gives px_valid at R+1.
- fl_req deasserts the cycle after fl_gnt. No new request is issued before fl_rvalid.
- in_ready is 0 in REQ and WAIT, and in OUT when px_ready is 0.

## Test plan
- Miss then fill: offset 0x105, char 0x41 gives A=0x82105. Expect fl_addr=0x10420 and fl_req at N+1. With fl_gnt at N+2 and fl_rvalid at N+4 carrying 0x04, expect px_valid at N+5 with px_color=fg and matching tag.
- Cache hit: after the miss above, send offset 0x106, char 0x41. Expect no fl_req, px_valid at the next cycle, px_color=bg (bit 1 of 0x04 is 0). Back-to-back hits with px_ready held at 1 give one pixel per cycle.
- Wrap: offset 0x3FFFFFFF, char 0xFF gives A=0x001FDFFF. Expect fl_addr=0x03FBFF. fl_rdata=0x01 gives px_color=fg.
- Backpressure: hold px_ready=0 for 5 cycles in OUT. Expect px_color and px_tag stable and in_ready=0. Release px_ready. Expect exactly one transfer and in_ready=1 in the same cycle.
- cache_inv: assert cache_inv during a WAIT fill, then repeat the same address. Expect a second fl_req. Assert cache_inv on a cycle with no transaction, then repeat the address. Expect a refetch.
- Reset mid-operation: drop rst_n in WAIT, release it, then pulse fl_rvalid. Expect no px_valid, fl_req=0, and the next request to the same address to be a miss.
